// File: rtl/bs_tap_pkg.sv
// Shared TAP state encodings (IEEE 1149.1 Table 6-3) and default opcodes.
package bs_tap_pkg;

  typedef enum logic [3:0] {
    EXIT2_DR         = 4'h0,
    EXIT1_DR         = 4'h1,
    SHIFT_DR         = 4'h2,
    PAUSE_DR         = 4'h3,
    SELECT_IR        = 4'h4,
    UPDATE_DR        = 4'h5,
    CAPTURE_DR       = 4'h6,
    SELECT_DR        = 4'h7,
    EXIT2_IR         = 4'h8,
    EXIT1_IR         = 4'h9,
    SHIFT_IR         = 4'hA,
    PAUSE_IR         = 4'hB,
    RUN_IDLE         = 4'hC,
    UPDATE_IR        = 4'hD,
    CAPTURE_IR       = 4'hE,
    TEST_LOGIC_RESET = 4'hF
  } tap_state_t;

  localparam int         IR_WIDTH_DEF  = 4;
  localparam logic [3:0] OP_EXTEST_DEF = 4'b0000;
  localparam logic [3:0] OP_SAMPLE_DEF = 4'b0001;
  localparam logic [3:0] OP_BYPASS_DEF = 4'b1111;

endpackage

// File: rtl/bs_tap_fsm.sv
// TAP state register and next-state logic; one transition per TCK, never stalls.
// state_nxt is exposed so the parent can act on the state being entered.
module bs_tap_fsm
  import bs_tap_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tms,
  output tap_state_t state,
  output tap_state_t state_nxt
);

  tap_state_t state_q, state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      TEST_LOGIC_RESET: state_d = tms ? TEST_LOGIC_RESET : RUN_IDLE;
      RUN_IDLE:         state_d = tms ? SELECT_DR        : RUN_IDLE;
      SELECT_DR:        state_d = tms ? SELECT_IR        : CAPTURE_DR;
      SELECT_IR:        state_d = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_DR:       state_d = tms ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         state_d = tms ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         state_d = tms ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         state_d = tms ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         state_d = tms ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        state_d = tms ? SELECT_DR        : RUN_IDLE;
      CAPTURE_IR:       state_d = tms ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         state_d = tms ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         state_d = tms ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         state_d = tms ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         state_d = tms ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        state_d = tms ? SELECT_DR        : RUN_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TEST_LOGIC_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  assign state     = state_q;
  assign state_nxt = state_d;

endmodule

// File: rtl/bs_tap_controller.sv
// IEEE 1149.1 TAP controller: IR, bypass bit and boundary-scan cell controls.
// TDO/TdoEn lag the state by one TCK; cell controls decode the current state.
module bs_tap_controller
  import bs_tap_pkg::*;
#(
  parameter int                  IR_WIDTH  = IR_WIDTH_DEF,
  parameter logic [IR_WIDTH-1:0] OP_EXTEST = IR_WIDTH'(OP_EXTEST_DEF),
  parameter logic [IR_WIDTH-1:0] OP_SAMPLE = IR_WIDTH'(OP_SAMPLE_DEF),
  parameter logic [IR_WIDTH-1:0] OP_BYPASS = '1
) (
  input  logic                Clock,
  input  logic                Rst,
  input  logic                TMS,
  input  logic                TDI,
  input  logic                BsrSout,
  output logic                BsrSin,
  output logic                ShiftBR,
  output logic                ClockBR,
  output logic                UpdateBR,
  output logic                ModeControl,
  output logic                RstBar,
  output logic                TDO,
  output logic                TdoEn,
  output logic [3:0]          TapState,
  output logic [IR_WIDTH-1:0] Instruction
);

  tap_state_t          state, state_nxt;
  logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d;
  logic [IR_WIDTH-1:0] instr_q, instr_d;
  logic                bypass_q, bypass_d;
  logic                tdo_q, tdo_d;
  logic                tdo_en_q, tdo_en_d;
  logic                bsr_sel;

  bs_tap_fsm u_fsm (
    .clk       (Clock),
    .rst       (Rst),
    .tms       (TMS),
    .state     (state),
    .state_nxt (state_nxt)
  );

  // Any opcode other than EXTEST/SAMPLE falls back to the bypass path.
  assign bsr_sel = (instr_q == OP_EXTEST) || (instr_q == OP_SAMPLE);

  always_comb begin
    ir_sr_d  = ir_sr_q;
    instr_d  = instr_q;
    bypass_d = bypass_q;
    tdo_d    = tdo_q;
    tdo_en_d = (state == SHIFT_IR) || (state == SHIFT_DR);
    case (state)
      CAPTURE_IR: ir_sr_d = {{(IR_WIDTH-1){1'b0}}, 1'b1};
      SHIFT_IR: begin
        ir_sr_d = {TDI, ir_sr_q[IR_WIDTH-1:1]};
        tdo_d   = ir_sr_q[0];
      end
      UPDATE_IR: instr_d = ir_sr_q;
      CAPTURE_DR: begin
        if (!bsr_sel) bypass_d = 1'b0;
      end
      SHIFT_DR: begin
        if (!bsr_sel) bypass_d = TDI;
        tdo_d = bsr_sel ? BsrSout : bypass_q;
      end
      default: ;
    endcase
    // Looking at the entered state makes Instruction read BYPASS in the same cycle as TLR.
    if (state_nxt == TEST_LOGIC_RESET) instr_d = OP_BYPASS;
  end

  always_ff @(posedge Clock) begin
    if (Rst) begin
      ir_sr_q  <= '0;
      instr_q  <= OP_BYPASS;
      bypass_q <= 1'b0;
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      ir_sr_q  <= ir_sr_d;
      instr_q  <= instr_d;
      bypass_q <= bypass_d;
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  end

  assign BsrSin      = TDI;
  assign ShiftBR     = bsr_sel && (state == SHIFT_DR);
  assign ClockBR     = bsr_sel && ((state == CAPTURE_DR) || (state == SHIFT_DR));
  assign UpdateBR    = bsr_sel && (state == UPDATE_DR);
  assign ModeControl = (instr_q == OP_EXTEST);
  assign RstBar      = (state != TEST_LOGIC_RESET);
  assign TDO         = tdo_q;
  assign TdoEn       = tdo_en_q;
  assign TapState    = state;
  assign Instruction = instr_q;

endmodule
